timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Programmable timer controller (TIMA/TMA/TAC, FF05–FF07) and FF04 write sequencer for the DMG divider.
- Consumes the free-running M-cycle divider count and selects a tap per TAC. Increments TIMA on the tap's falling edge.
- Sequences overflow, reload and timer-interrupt timing, and emits the divider-reset strobe on FF04 writes.
- Sits between the CPU bus decode (ff04_ff07 select) and the interrupt controller.

Parameters:
- DIV_W, 8, width of divider count input; must be ≥ 8.
- RELOAD_CYC, 1, cycles TIMA reads 00 after overflow before reload; legal range 1..3.

Ports:
- clk  in  1  M-cycle clock (1.048576 MHz)
- reset  in  1  synchronous, active-high
- cs  in  1  ff04_ff07 decode
- addr  in  2  register offset (0=FF04, 1=FF05, 2=FF06, 3=FF07)
- wr  in  1  CPU write strobe, one clk per access
- rd  in  1  CPU read strobe
- wdata  in  8  CPU write data
- rdata  out  8  read data
- rdata_oe  out  1  high when rdata drives the bus
- div_cnt  in  DIV_W  divider count, increments once per clk
- div_reset  out  1  one-clk pulse clearing the divider
- irq_timer  out  1  one-clk interrupt request pulse
- tima  out  8  counter value
- tma  out  8  modulo value
- tac  out  3  control value

Behaviour:
- Reset values: tima=00, tma=00, tac=0, irq_timer=0, div_reset=0, rdata=00, rdata_oe=0, state=S_RUN, tap history=0, delay counter=0.
- Tap select, by tac[1:0]:
  - 00 → div_cnt[7] (4096 Hz)
  - 01 → div_cnt[1] (262144 Hz)
  - 10 → div_cnt[3] (65536 Hz)
  - 11 → div_cnt[5] (16384 Hz)
- sel = tac[2] & tap. inc = sel_q & !sel, where sel_q is sel registered each clk.
  - TAC writes and divider resets that drop sel produce an increment. This DMG glitch is required behaviour.
- div_reset = cs & wr & addr==0, combinational, one pulse per write. The FF04 write does nothing else.
- TAC write: tac ← wdata[2:0], effective next clk.
- TMA write: tma ← wdata, effective next clk.
- FSM states: S_RUN, S_OVF, S_RELOAD.
- S_RUN:
  - TIMA write wins over a same-cycle inc: tima ← wdata.
  - inc with tima≠FF: tima+1.
  - inc with tima=FF: tima ← 00, delay counter ← RELOAD_CYC−1, go to S_OVF.
- S_OVF:
  - tima holds 00. inc events are discarded.
  - A TIMA write loads wdata, cancels the reload (no irq), and returns to S_RUN.
  - Otherwise, when the delay counter is 0: tima ← tma, irq_timer=1 for that clk, go to S_RELOAD. Same-cycle TMA writes bypass, so tima takes the new wdata.
  - Otherwise the delay counter decrements.
- S_RELOAD (exactly one clk):
  - TIMA writes are ignored.
  - TMA writes update both tma and tima.
  - inc is discarded.
  - Go to S_RUN.
- Reads (rd & cs):
  - rdata_oe=1 only for addr 1..3; addr 0 leaves the bus to the divider.
  - rdata is combinational from current registers: addr1=tima, addr2=tma, addr3={5'b11111,tac}.
  - When rdata_oe=0, rdata=00.
- reset mid-overflow: immediate return to S_RUN with reset values; no irq pulse.
- rd and wr together: the write takes effect; rdata shows the pre-write value.

Decomposition:
- timer_pkg:
  - state enum (S_RUN, S_OVF, S_RELOAD)
  - register offsets ADDR_DIV/TIMA/TMA/TAC
  - tap index constants TAP_00..TAP_11 = 7,1,3,5
  - TAC read pad 5'b11111
- Sub-module timer_tap_edge: tap mux, enable AND, sel_q register, falling-edge detect. Ports clk, reset, div_cnt, tac, inc.

Test Plan:
- TAC=5 (enable, tap bit1), TMA=00, TIMA=FE, free-run div_cnt → TIMA increments every 4 clk. FF→00, held 1 clk, then reloads 00 with one irq_timer pulse. Exactly 1 irq per 256 increments.
- TMA=0xAB, TIMA=FF, overflow → TIMA=00 for 1 clk, then AB with irq=1 that clk. TMA write 0x55 in the S_OVF clk → TIMA=55.
- TIMA write 0x12 during S_OVF → TIMA=12, no irq, S_RUN. TIMA write 0x34 during S_RELOAD → ignored, TIMA keeps TMA. TMA write 0x77 in S_RELOAD → TIMA=77.
- TAC=4 with div_cnt[7]=1, then write TAC=0 → TIMA +1 (glitch). With div_cnt[7]=0 → no change. FF04 write → div_reset one pulse; increment only if the selected tap was 1.
- Reads: addr3 after TAC=0x02 → rdata=F A (0xFA), rdata_oe=1. addr0 read → rdata_oe=0, rdata=00. rd+wr TIMA → old value read, new value next clk.
- Assert reset during S_OVF → next clk all reset values, irq_timer stays 0. Increment resumes from TIMA=00 once TAC is re-enabled.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer block (TIMA/TMA/TAC, FF04-FF07).
// Contents:
//   timer_state_t : overflow sequencing states
//   ADDR_*        : register offsets within the ff04_ff07 window
//   TAP_*         : divider bit selected by each TAC[1:0] code
//   TAC_PAD       : constant upper bits returned when TAC is read
package timer_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_OVF    = 2'd1,
    S_RELOAD = 2'd2
  } timer_state_t;

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  // Divider bit used as the timer clock for each TAC[1:0] code
  localparam int TAP_00 = 7;  // 4096 Hz
  localparam int TAP_01 = 1;  // 262144 Hz
  localparam int TAP_10 = 3;  // 65536 Hz
  localparam int TAP_11 = 5;  // 16384 Hz

  localparam logic [4:0] TAC_PAD = 5'b11111;

endpackage

// File: rtl/timer_tap_edge.sv
// Timer clock source: picks the divider tap chosen by TAC, gates it with the
// enable bit and produces a one-clk increment on the falling edge of the gated
// signal.
// Ports:
//   clk     : M-cycle clock
//   reset   : synchronous, active-high
//   div_cnt : free-running divider count
//   tac     : timer control {enable, tap select[1:0]}
//   inc     : one-clk TIMA increment request
module timer_tap_edge
  import timer_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_cnt,
  input  logic [2:0]       tac,
  output logic             inc
);

  logic w_tap;
  logic w_sel;
  logic r_sel_q;

  always_comb begin
    w_tap = 1'b0;
    case (tac[1:0])
      2'b00:   w_tap = div_cnt[TAP_00];
      2'b01:   w_tap = div_cnt[TAP_01];
      2'b10:   w_tap = div_cnt[TAP_10];
      default: w_tap = div_cnt[TAP_11];
    endcase
  end

  // The enable is ANDed before the edge detector on purpose: clearing the
  // enable (or the divider) while the tap is high looks like a falling edge
  // and bumps TIMA, matching the original hardware.
  assign w_sel = tac[2] & w_tap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_q <= 1'b0;
    end else begin
      r_sel_q <= w_sel;
    end
  end

  assign inc = r_sel_q & ~w_sel;

  // Divider bits that are never selected as a tap
  logic w_unused_div;
  generate
    if (DIV_W > 8) begin : g_wide
      assign w_unused_div = ^{div_cnt[DIV_W-1:8], div_cnt[6], div_cnt[4],
                              div_cnt[2], div_cnt[0]};
    end else begin : g_narrow
      assign w_unused_div = ^{div_cnt[6], div_cnt[4], div_cnt[2], div_cnt[0]};
    end
  endgenerate

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer controller: TIMA counter, TMA modulo, TAC control, the
// overflow -> reload -> interrupt sequence, and the FF04 divider-reset strobe.
// Ports:
//   clk, reset            : M-cycle clock, synchronous active-high reset
//   cs, addr, wr, rd      : CPU access to FF04..FF07 (addr = offset)
//   wdata                 : CPU write data
//   rdata, rdata_oe       : read data and bus-drive enable (FF05..FF07 only)
//   div_cnt               : free-running divider count
//   div_reset             : one-clk pulse clearing the divider on FF04 write
//   irq_timer             : one-clk timer interrupt request
//   tima, tma, tac        : current register values
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int RELOAD_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic [1:0]       addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             rdata_oe,
  input  logic [DIV_W-1:0] div_cnt,
  output logic             div_reset,
  output logic             irq_timer,
  output logic [7:0]       tima,
  output logic [7:0]       tma,
  output logic [2:0]       tac
);

  // Counter preset so that TIMA reads 00 for RELOAD_CYC clks after overflow
  localparam logic [1:0] DLY_INIT = 2'(RELOAD_CYC - 1);

  timer_state_t r_state, w_state_next;
  logic [7:0]   r_tima, w_tima_next;
  logic [7:0]   r_tma, w_tma_next;
  logic [2:0]   r_tac, w_tac_next;
  logic [1:0]   r_dly, w_dly_next;
  logic         r_irq, w_irq_next;

  logic w_inc;
  logic w_tima_wr;
  logic w_tma_wr;
  logic w_tac_wr;

  timer_tap_edge #(
    .DIV_W (DIV_W)
  ) u_tap_edge (
    .clk     (clk),
    .reset   (reset),
    .div_cnt (div_cnt),
    .tac     (r_tac),
    .inc     (w_inc)
  );

  assign w_tima_wr = cs & wr & (addr == ADDR_TIMA);
  assign w_tma_wr  = cs & wr & (addr == ADDR_TMA);
  assign w_tac_wr  = cs & wr & (addr == ADDR_TAC);
  assign div_reset = cs & wr & (addr == ADDR_DIV);

  always_comb begin
    w_state_next = r_state;
    w_tima_next  = r_tima;
    w_tma_next   = r_tma;
    w_tac_next   = r_tac;
    w_dly_next   = r_dly;
    w_irq_next   = 1'b0;

    if (w_tma_wr) begin
      w_tma_next = wdata;
    end
    if (w_tac_wr) begin
      w_tac_next = wdata[2:0];
    end

    case (r_state)
      S_RUN: begin
        if (w_tima_wr) begin
          w_tima_next = wdata;
        end else if (w_inc) begin
          if (r_tima == 8'hFF) begin
            w_tima_next  = 8'h00;
            w_dly_next   = DLY_INIT;
            w_state_next = S_OVF;
          end else begin
            w_tima_next = r_tima + 8'd1;
          end
        end
      end

      S_OVF: begin
        if (w_tima_wr) begin
          // CPU write aborts the pending reload and its interrupt
          w_tima_next  = wdata;
          w_state_next = S_RUN;
        end else if (r_dly == 2'd0) begin
          // A TMA write landing on the reload clk is forwarded into TIMA
          w_tima_next  = w_tma_wr ? wdata : r_tma;
          w_irq_next   = 1'b1;
          w_state_next = S_RELOAD;
        end else begin
          w_dly_next = r_dly - 2'd1;
        end
      end

      S_RELOAD: begin
        // TIMA is locked to TMA for this clk; TIMA writes are dropped
        if (w_tma_wr) begin
          w_tima_next = wdata;
        end
        w_state_next = S_RUN;
      end

      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_tima  <= 8'h00;
      r_tma   <= 8'h00;
      r_tac   <= 3'd0;
      r_dly   <= 2'd0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tima  <= w_tima_next;
      r_tma   <= w_tma_next;
      r_tac   <= w_tac_next;
      r_dly   <= w_dly_next;
      r_irq   <= w_irq_next;
    end
  end

  // Read path shows current register contents, so a same-clk write is not
  // visible until the following clk.
  always_comb begin
    rdata    = 8'h00;
    rdata_oe = 1'b0;
    if (cs & rd) begin
      case (addr)
        ADDR_TIMA: begin
          rdata    = r_tima;
          rdata_oe = 1'b1;
        end
        ADDR_TMA: begin
          rdata    = r_tma;
          rdata_oe = 1'b1;
        end
        ADDR_TAC: begin
          rdata    = {TAC_PAD, r_tac};
          rdata_oe = 1'b1;
        end
        default: begin
          rdata    = 8'h00;
          rdata_oe = 1'b0;
        end
      endcase
    end
  end

  assign irq_timer = r_irq;
  assign tima      = r_tima;
  assign tma       = r_tma;
  assign tac       = r_tac;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: a reference model computes the expected
// outputs for every clk, pushes them into a queue, and a monitor on the
// falling edge pops and compares them against the DUT.
module tb_timer_ctrl;

  localparam int RELOAD_CYC = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] div_cnt = 8'h00;
  logic [7:0] rdata;
  logic       rdata_oe;
  logic       div_reset;
  logic       irq_timer;
  logic [7:0] tima;
  logic [7:0] tma;
  logic [2:0] tac;

  always #5 clk = ~clk;

  timer_ctrl #(
    .DIV_W      (8),
    .RELOAD_CYC (RELOAD_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .addr      (addr),
    .wr        (wr),
    .rd        (rd),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_oe  (rdata_oe),
    .div_cnt   (div_cnt),
    .div_reset (div_reset),
    .irq_timer (irq_timer),
    .tima      (tima),
    .tma       (tma),
    .tac       (tac)
  );

  typedef struct {
    logic [7:0] tima;
    logic [7:0] tma;
    logic [2:0] tac;
    logic       irq;
    logic       divr;
    logic       oe;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_irq_seen = 0;

  // Reference model state
  int m_tima, m_tma, m_tac, m_div;
  int m_zero_left;   // clks of 00 still to show before the reload happens
  bit m_in_reload;   // the clk right after a reload
  bit m_prev_sel;
  bit m_irq;

  function automatic int tap_bit(input int t);
    case (t & 3)
      0:       return 7;
      1:       return 1;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%02h exp=%02h", name, $time, got, exp);
    end
  endtask

  // Monitor: one expectation per clk, compared mid-cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tima", tima, e.tima);
      chk("tma", tma, e.tma);
      chk("tac", {5'd0, tac}, {5'd0, e.tac});
      chk("irq_timer", {7'd0, irq_timer}, {7'd0, e.irq});
      chk("div_reset", {7'd0, div_reset}, {7'd0, e.divr});
      chk("rdata_oe", {7'd0, rdata_oe}, {7'd0, e.oe});
      chk("rdata", rdata, e.rdata);
      if (irq_timer === 1'b1) n_irq_seen++;
    end
  end

  task automatic model_reset();
    m_tima = 0; m_tma = 0; m_tac = 0;
    m_zero_left = 0; m_in_reload = 0; m_prev_sel = 0; m_irq = 0;
  endtask

  // One clk: drive inputs, predict outputs, advance the model across the edge
  task automatic cycle(input bit rst, input bit c, input logic [1:0] a,
                       input bit w, input bit r, input logic [7:0] d);
    exp_t e;
    bit   sel, inc, divr;
    int   new_tma;
    @(posedge clk);
    #1;
    reset = rst; cs = c; addr = a; wr = w; rd = r; wdata = d;
    div_cnt = 8'(m_div);
    if (c && (w || r))
      $display("t=%0t access addr=%0d wr=%0b rd=%0b wdata=%02h", $time, a, w, r, d);

    divr    = c && w && (a == 2'd0);
    e.tima  = 8'(m_tima);
    e.tma   = 8'(m_tma);
    e.tac   = 3'(m_tac);
    e.irq   = m_irq;
    e.divr  = divr;
    e.oe    = c && r && (a != 2'd0);
    e.rdata = !e.oe ? 8'h00 : (a == 2'd1) ? 8'(m_tima) :
              (a == 2'd2) ? 8'(m_tma) : 8'(8'hF8 | m_tac);
    exp_q.push_back(e);

    sel = (((m_tac >> 2) & 1) == 1) && (((m_div >> tap_bit(m_tac)) & 1) == 1);
    inc = m_prev_sel && !sel;
    m_prev_sel = sel;
    m_div = divr ? 0 : (m_div + 1) % 256;

    if (rst) begin
      model_reset();
    end else begin
      new_tma = (c && w && a == 2'd2) ? int'(d) : m_tma;
      m_irq = 0;
      if (m_in_reload) begin
        if (c && w && a == 2'd2) m_tima = d;
        m_in_reload = 0;
      end else if (m_zero_left > 0) begin
        if (c && w && a == 2'd1) begin
          m_tima = d;
          m_zero_left = 0;
        end else if (m_zero_left == 1) begin
          m_tima = new_tma;
          m_irq = 1;
          m_in_reload = 1;
          m_zero_left = 0;
        end else begin
          m_zero_left--;
        end
      end else if (c && w && a == 2'd1) begin
        m_tima = d;
      end else if (inc) begin
        if (m_tima == 255) begin
          m_tima = 0;
          m_zero_left = RELOAD_CYC;
        end else begin
          m_tima++;
        end
      end
      m_tma = new_tma;
      if (c && w && a == 2'd3) m_tac = d & 7;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 2'd0, 0, 0, 8'h00);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    cycle(0, 1, a, 1, 0, d);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    cycle(0, 1, a, 0, 1, 8'h00);
  endtask

  task automatic wait_ovf();
    int k = 0;
    while (m_zero_left == 0 && k < 3000) begin
      idle(1);
      k++;
    end
    n_cmp++;
    if (m_zero_left == 0) begin
      n_bad++;
      $display("FAIL wait_ovf got=timeout exp=overflow");
    end
  endtask

  task automatic wait_reload();
    wait_ovf();
    while (m_zero_left > 0) idle(1);
  endtask

  task automatic wait_div7(input int v);
    int k = 0;
    while (((m_div >> 7) & 1) != v && k < 400) begin
      idle(1);
      k++;
    end
  endtask

  initial begin
    int r, irq_before;
    logic [1:0] a;
    logic [7:0] d;

    model_reset();
    m_div = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    cycle(1, 0, 2'd0, 0, 0, 8'h00);   // reset state observed here
    idle(2);

    // Free-run overflow with TMA=00
    wr_reg(2'd3, 8'h05);
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd1, 8'hFE);
    idle(40);

    // Overflow reloads TMA=AB with an irq
    wr_reg(2'd2, 8'hAB);
    wr_reg(2'd1, 8'hFF);
    wait_ovf();
    idle(3);

    // TMA write during the overflow clk is forwarded
    wr_reg(2'd1, 8'hFF);
    wait_ovf();
    wr_reg(2'd2, 8'h55);
    idle(3);

    // TIMA write during overflow cancels the reload
    wr_reg(2'd1, 8'hFF);
    wait_ovf();
    irq_before = n_irq_seen;
    wr_reg(2'd1, 8'h12);
    idle(3);
    n_cmp++;
    if (n_irq_seen != irq_before) begin
      n_bad++;
      $display("FAIL cancel_irq got=%0d exp=%0d", n_irq_seen - irq_before, 0);
    end

    // TIMA write in the reload clk is ignored, TMA write is taken
    wr_reg(2'd1, 8'hFF);
    wait_reload();
    wr_reg(2'd1, 8'h34);
    idle(2);
    wr_reg(2'd1, 8'hFF);
    wait_reload();
    wr_reg(2'd2, 8'h77);
    idle(2);

    // Disable glitch: tap high -> increment, tap low -> nothing
    wr_reg(2'd1, 8'h40);
    wr_reg(2'd3, 8'h04);
    wait_div7(1);
    wr_reg(2'd3, 8'h00);
    idle(2);
    wr_reg(2'd3, 8'h04);
    wait_div7(0);
    wr_reg(2'd3, 8'h00);
    idle(2);

    // FF04 writes with a fast tap, at varying phases
    wr_reg(2'd3, 8'h05);
    for (int i = 0; i < 6; i++) begin
      idle(1 + (i % 3));
      wr_reg(2'd0, 8'h00);
      idle(2);
    end

    // Reads
    wr_reg(2'd3, 8'h02);
    rd_reg(2'd3);
    rd_reg(2'd0);
    rd_reg(2'd2);
    cycle(0, 1, 2'd1, 1, 1, 8'hC3);
    rd_reg(2'd1);

    // Reset in the middle of an overflow
    wr_reg(2'd3, 8'h05);
    wr_reg(2'd1, 8'hFF);
    wait_ovf();
    cycle(1, 0, 2'd0, 0, 0, 8'h00);
    idle(3);
    wr_reg(2'd3, 8'h05);
    idle(20);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd1 && $urandom_range(0, 1) == 1) d = d | 8'hF0;
      if (a == 2'd3 && $urandom_range(0, 3) != 0) d = d | 8'h04;
      if (r < 1) cycle(1, 0, 2'd0, 0, 0, 8'h00);
      else if (r < 12) wr_reg(a, d);
      else if (r < 14) cycle(0, 1, a, 1, 1, d);
      else if (r < 30) rd_reg(a);
      else if (r < 33) cycle(0, 0, a, 1, 1, d);
      else idle(1);
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
